bcd_seg_scan: RTL and testbench
===============================

Name: bcd_seg_scan

Overview:
- Downstream display stage for the 8-bit binary-to-BCD converter.
- Takes its 12-bit BCD output (hundreds/tens/ones nibbles) and drives a 3-digit, time-multiplexed, common-anode seven-segment display.
- New values are double-buffered and committed only at scan-frame boundaries, so a digit never tears mid-frame.
- Also provides leading-zero blanking and invalid-digit flagging.

Parameters:
- CLK_DIV, 50000, clk cycles per digit slot (must be >= 2).
- DIV_W, 16, prescaler counter width (must satisfy 2^DIV_W >= CLK_DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bcd_in  input  12  {hundreds[11:8], tens[7:4], ones[3:0]}.
- load  input  1  single-cycle strobe: capture bcd_in.
- blank_lz  input  1  1 = blank leading zeros.
- an  output  3  digit enables, active-low; an[0]=ones, an[2]=hundreds.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- upd_pending  output  1  a captured value is waiting for frame commit.
- digit_err  output  1  the displayed value contains a nibble > 9.

Behaviour:
- Reset (async, rst_n=0) takes effect immediately, including mid-frame or mid-slot, and clears all state:
  - prescaler=0, idx=0, disp=0, pend_val=0, upd_pending=0.
  - an=3'b111, seg=7'h7F, digit_err=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps to 0.
  - tick=1 in the cycle where count==CLK_DIV-1.
- Digit index idx:
  - Advances on tick in the order 0->1->2->0.
  - Frame boundary = tick while idx==2.
- Load and commit (priority high to low):
  - load and frame boundary in the same cycle: disp<=bcd_in; pend_val is discarded; upd_pending<=0.
  - load otherwise: pend_val<=bcd_in, upd_pending<=1. Later loads before the commit overwrite earlier ones (last wins).
  - Frame boundary with upd_pending=1: disp<=pend_val, upd_pending<=0.
  - load is never back-pressured.
- Outputs are registered and reflect the current idx and disp with 1-cycle latency.
  - After reset release, the first clk edge gives an=3'b110 and seg showing the ones digit of disp.
- an: exactly one bit low per cycle after reset; an[idx]=0.
- seg decode of the selected nibble:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - 10..15 = 3F (segment g only, dash).
- Leading-zero blanking (blank_lz=1):
  - Hundreds is blanked (seg=7F) if its nibble is 0.
  - Tens is blanked if tens==0 and hundreds==0.
  - Ones is never blanked.
  - Anodes still scan when a digit is blanked.
  - A nibble > 9 is never treated as zero.
  - blank_lz is sampled each cycle; no buffering.
- digit_err = OR over disp nibbles of (nibble > 9), registered with the same latency as seg.
  - Sets when an invalid value commits.
  - Clears when a valid value commits.
- bcd_in[11:10] are decoded as-is; no masking.

Test Plan (CLK_DIV=4):
- rst_n=0 for 3 cycles -> an=111, seg=7F, upd_pending=0. Release -> next edge an=110, seg=40; tick every 4 cycles; an cycles 110->101->011->110.
- After reset, load=1 with bcd_in=12'h255 while idx=0 -> upd_pending=1 until the idx==2 tick. From the following slot: ones seg=12, tens seg=12, hundreds seg=24. upd_pending then 0, digit_err=0.
- Commit 12'h007:
  - blank_lz=1 -> hundreds seg=7F, tens seg=7F, ones seg=78.
  - blank_lz=0 -> hundreds seg=40, tens seg=40.
  - Commit 12'h107 with blank_lz=1 -> tens shows 40 (not blanked).
- Coincidence and overwrite:
  - load 12'h123 in the exact frame-boundary cycle -> committed immediately, upd_pending stays 0.
  - Loads of 12'h111 then 12'h222 in one frame -> only 222 is displayed; 111 never appears on seg.
- Invalid digit: commit 12'h0A3 -> tens seg=3F, digit_err=1. Then load 12'h042 -> digit_err stays 1 until the commit boundary, then 0.
- Reset mid-operation: assert rst_n=0 mid-slot with idx=1 and upd_pending=1 -> same cycle an=111, seg=7F, upd_pending=0. After release the display shows 0 (ones seg=40) and the pending value is lost.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// 3-digit multiplexed common-anode 7-seg driver for a 12-bit BCD value.
// Values are double-buffered and committed only at scan-frame boundaries.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       async active-low reset
//   bcd_in      {hundreds, tens, ones} BCD nibbles
//   load        one-cycle strobe, captures bcd_in
//   blank_lz    1 = blank leading zeros
//   an          digit enables, active-low (an[0] = ones)
//   seg         {g,f,e,d,c,b,a}, active-low
//   upd_pending captured value waiting for the next frame boundary
//   digit_err   displayed value holds a nibble > 9
module bcd_seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic        upd_pending,
  output logic        digit_err
);

  typedef enum logic [1:0] {
    D_ONES = 2'd0,
    D_TENS = 2'd1,
    D_HUND = 2'd2
  } idx_e;

  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_DIV - 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  logic [DIV_W-1:0] div_q, div_d;
  idx_e             idx_q, idx_d;
  logic [11:0]      disp_q, disp_d;
  logic [11:0]      pend_q, pend_d;
  logic             pv_q, pv_d;
  logic [2:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             err_q, err_d;

  logic             tick;
  logic             frame;

  logic [3:0]       hun, ten, one;
  logic [3:0]       nib;
  logic             h_zero, t_zero;
  logic             blank;

  // Prescaler: one tick per digit slot.
  assign tick = (div_q == DIV_MAX);

  always_comb begin
    div_d = div_q + 1'b1;
    if (tick) begin
      div_d = '0;
    end
  end

  // Scan index state machine.
  assign frame = tick && (idx_q == D_HUND);

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      unique case (idx_q)
        D_ONES:  idx_d = D_TENS;
        D_TENS:  idx_d = D_HUND;
        D_HUND:  idx_d = D_ONES;
        default: idx_d = D_ONES;
      endcase
    end
  end

  // Double buffer. A load landing exactly on the
  // boundary goes straight to the display and
  // supersedes anything still pending.
  always_comb begin
    disp_d = disp_q;
    pend_d = pend_q;
    pv_d   = pv_q;
    if (load && frame) begin
      disp_d = bcd_in;
      pv_d   = 1'b0;
    end else if (load) begin
      pend_d = bcd_in;
      pv_d   = 1'b1;
    end else if (frame && pv_q) begin
      disp_d = pend_q;
      pv_d   = 1'b0;
    end
  end

  // Output stage: decode the current slot.
  assign hun = disp_q[11:8];
  assign ten = disp_q[7:4];
  assign one = disp_q[3:0];

  assign h_zero = (hun == 4'd0);
  assign t_zero = (ten == 4'd0);

  always_comb begin
    nib   = one;
    an_d  = 3'b110;
    blank = 1'b0;
    unique case (1'b1)
      (idx_q == D_TENS): begin
        nib   = ten;
        an_d  = 3'b101;
        blank = blank_lz && t_zero && h_zero;
      end
      (idx_q == D_HUND): begin
        nib   = hun;
        an_d  = 3'b011;
        blank = blank_lz && h_zero;
      end
      default: begin
        nib   = one;
        an_d  = 3'b110;
        blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    seg_d = SEG_DASH;
    if (blank) begin
      seg_d = SEG_OFF;
    end else begin
      unique case (nib)
        4'd0:    seg_d = 7'h40;
        4'd1:    seg_d = 7'h79;
        4'd2:    seg_d = 7'h24;
        4'd3:    seg_d = 7'h30;
        4'd4:    seg_d = 7'h19;
        4'd5:    seg_d = 7'h12;
        4'd6:    seg_d = 7'h02;
        4'd7:    seg_d = 7'h78;
        4'd8:    seg_d = 7'h00;
        4'd9:    seg_d = 7'h10;
        default: seg_d = SEG_DASH;
      endcase
    end
  end

  assign err_d = (hun > 4'd9) ||
                 (ten > 4'd9) ||
                 (one > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      idx_q  <= D_ONES;
      disp_q <= '0;
      pend_q <= '0;
      pv_q   <= 1'b0;
      an_q   <= 3'b111;
      seg_q  <= SEG_OFF;
      err_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      err_q  <= err_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign upd_pending = pv_q;
  assign digit_err   = err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with CLK_DIV=4.
// Edge k after reset release is tracked in cyc.
module tb_bcd_seg_scan;

  logic        clk;
  logic        rst_n;
  logic [11:0] bcd_in;
  logic        load;
  logic        blank_lz;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        upd_pending;
  logic        digit_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  bcd_seg_scan #(
    .CLK_DIV(4),
    .DIV_W(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bcd_in(bcd_in),
    .load(load),
    .blank_lz(blank_lz),
    .an(an),
    .seg(seg),
    .upd_pending(upd_pending),
    .digit_err(digit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic tk();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tk();
  endtask

  task automatic chk(input string tag,
                     input logic [11:0] obs,
                     input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bcd_in   = '0;
    load     = 1'b0;
    blank_lz = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 12'(an), 12'h7);
    chk("rst_seg", 12'(seg), 12'h7F);
    chk("rst_upd", 12'(upd_pending), 12'h0);
    chk("rst_err", 12'(digit_err), 12'h0);

    rst_n = 1'b1;
    cyc   = 0;

    run_to(1);
    chk("e1_an", 12'(an), 12'h6);
    chk("e1_seg", 12'(seg), 12'h40);
    run_to(4);
    chk("e4_an", 12'(an), 12'h6);
    run_to(5);
    chk("e5_an", 12'(an), 12'h5);
    chk("e5_seg", 12'(seg), 12'h40);
    run_to(9);
    chk("e9_an", 12'(an), 12'h3);
    run_to(13);
    chk("e13_an", 12'(an), 12'h6);

    // load 255 in slot 0, commit at E24
    bcd_in = 12'h255;
    load   = 1'b1;
    run_to(14);
    load = 1'b0;
    chk("l255_upd", 12'(upd_pending), 12'h1);
    run_to(23);
    chk("l255_upd_hold", 12'(upd_pending), 12'h1);
    run_to(24);
    chk("l255_upd_clr", 12'(upd_pending), 12'h0);
    run_to(25);
    chk("l255_ones", 12'(seg), 12'h12);
    chk("l255_err", 12'(digit_err), 12'h0);
    run_to(29);
    chk("l255_tens", 12'(seg), 12'h12);
    run_to(33);
    chk("l255_hund", 12'(seg), 12'h24);
    chk("l255_hund_an", 12'(an), 12'h3);

    // 007 with blanking, commit at E48
    run_to(37);
    bcd_in   = 12'h007;
    load     = 1'b1;
    blank_lz = 1'b1;
    run_to(38);
    load = 1'b0;
    run_to(49);
    chk("b007_ones", 12'(seg), 12'h78);
    run_to(53);
    chk("b007_tens", 12'(seg), 12'h7F);
    chk("b007_tens_an", 12'(an), 12'h5);
    run_to(57);
    chk("b007_hund", 12'(seg), 12'h7F);
    chk("b007_hund_an", 12'(an), 12'h3);
    blank_lz = 1'b0;

    // 107 loaded at E62, commit at E72
    run_to(61);
    bcd_in = 12'h107;
    load   = 1'b1;
    run_to(62);
    load = 1'b0;
    run_to(65);
    chk("n007_tens", 12'(seg), 12'h40);
    run_to(69);
    chk("n007_hund", 12'(seg), 12'h40);
    blank_lz = 1'b1;
    run_to(73);
    chk("b107_ones", 12'(seg), 12'h78);
    run_to(77);
    chk("b107_tens", 12'(seg), 12'h40);
    run_to(81);
    chk("b107_hund", 12'(seg), 12'h79);

    // load exactly on boundary E84
    run_to(83);
    bcd_in = 12'h123;
    load   = 1'b1;
    run_to(84);
    load = 1'b0;
    chk("c123_upd", 12'(upd_pending), 12'h0);
    run_to(85);
    chk("c123_ones", 12'(seg), 12'h30);

    // overwrite: 111 then 222, commit at E96
    bcd_in = 12'h111;
    load   = 1'b1;
    run_to(86);
    load = 1'b0;
    run_to(89);
    chk("c123_tens", 12'(seg), 12'h24);
    bcd_in = 12'h222;
    load   = 1'b1;
    run_to(90);
    load = 1'b0;
    chk("ow_upd", 12'(upd_pending), 12'h1);
    run_to(93);
    chk("c123_hund", 12'(seg), 12'h79);
    run_to(97);
    chk("ow_ones", 12'(seg), 12'h24);

    // 0A3 loaded at E98, commit at E108
    bcd_in = 12'h0A3;
    load   = 1'b1;
    run_to(98);
    load = 1'b0;
    run_to(101);
    chk("ow_tens", 12'(seg), 12'h24);
    run_to(105);
    chk("ow_hund", 12'(seg), 12'h24);
    for (int k = 106; k <= 108; k++) begin
      run_to(k);
      checks++;
      assert (seg !== 7'h79) else begin
        failures++;
        $error("FAIL ow_no111 obs=%h exp=not_79", seg);
      end
    end
    chk("inv_err_pre", 12'(digit_err), 12'h0);
    run_to(109);
    chk("inv_err_set", 12'(digit_err), 12'h1);
    chk("inv_ones", 12'(seg), 12'h30);

    // 042 loaded at E110, commit at E120
    bcd_in = 12'h042;
    load   = 1'b1;
    run_to(110);
    load = 1'b0;
    run_to(113);
    chk("inv_tens", 12'(seg), 12'h3F);
    run_to(117);
    chk("inv_hund", 12'(seg), 12'h7F);
    run_to(120);
    chk("inv_err_hold", 12'(digit_err), 12'h1);
    run_to(121);
    chk("inv_err_clr", 12'(digit_err), 12'h0);
    chk("v042_ones", 12'(seg), 12'h24);

    // reset mid-slot with idx=1 and a pending value
    run_to(125);
    bcd_in = 12'h999;
    load   = 1'b1;
    run_to(126);
    load = 1'b0;
    chk("mr_upd_pre", 12'(upd_pending), 12'h1);
    chk("mr_an_pre", 12'(an), 12'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_an", 12'(an), 12'h7);
    chk("mr_seg", 12'(seg), 12'h7F);
    chk("mr_upd", 12'(upd_pending), 12'h0);
    tk();
    tk();
    rst_n = 1'b1;
    cyc   = 0;
    run_to(1);
    chk("mr_e1_an", 12'(an), 12'h6);
    chk("mr_e1_seg", 12'(seg), 12'h40);
    run_to(12);
    chk("mr_upd_bnd", 12'(upd_pending), 12'h0);
    run_to(13);
    chk("mr_ones", 12'(seg), 12'h40);
    chk("mr_err", 12'(digit_err), 12'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
